// File: rtl/mu_vel_sequencer.sv
// Streams one cell's particle velocities cache -> FP update unit -> cache.
// Read issue is credit-limited so that no more than MAX_INFLIGHT particles sit between read and write-back.
module mu_vel_sequencer #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int DATA_WIDTH        = 32,
  parameter int MAX_INFLIGHT      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [PARTICLE_ID_WIDTH:0]   i_num_particles,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err,
  output logic                         o_MU_working,
  output logic [PARTICLE_ID_WIDTH-1:0] o_MU_rd_addr,
  output logic                         o_MU_rd_en,
  input  logic [3*DATA_WIDTH-1:0]      i_MU_vel,
  input  logic                         i_MU_vel_valid,
  output logic [3*DATA_WIDTH-1:0]      o_upd_vel,
  output logic [PARTICLE_ID_WIDTH-1:0] o_upd_id,
  output logic                         o_upd_valid,
  input  logic                         i_upd_ready,
  input  logic [3*DATA_WIDTH-1:0]      i_res_vel,
  input  logic                         i_res_valid,
  output logic                         o_MU_wr_en,
  output logic [3*DATA_WIDTH-1:0]      o_MU_wr_vel
);
  localparam int CW = PARTICLE_ID_WIDTH + 1;
  localparam int VW = 3 * DATA_WIDTH;
  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] num;
  logic [CW-1:0] rd_cnt;       // reads issued this pass
  logic [CW-1:0] cap_cnt;      // cache responses captured
  logic [CW-1:0] req_cnt;      // requests handed to the update unit
  logic [CW-1:0] res_cnt;      // results received
  logic [CW-1:0] wb_cnt;       // write-backs performed
  logic [CW-1:0] outstanding;
  logic          ignore;
  logic          err;
  logic          wr_en;
  logic [VW-1:0] wr_vel;

  logic [VW-1:0]                fifo_vel [MAX_INFLIGHT];
  logic [PARTICLE_ID_WIDTH-1:0] fifo_id  [MAX_INFLIGHT];
  logic [AW-1:0]                wptr;
  logic [AW-1:0]                rptr;
  logic [AW:0]                  fcnt;

  logic          rd_en;
  logic          cap;
  logic          pop;
  logic          res_ok;
  logic          stray;
  logic [CW-1:0] wb_next;

  // After a reset, responses belonging to the aborted pass may still trickle in;
  // 'ignore' swallows them silently until a new pass is started.
  assign rd_en   = (state == READ) && (outstanding < MAX_C);
  assign cap     = i_MU_vel_valid && !ignore && (rd_cnt != cap_cnt);
  assign pop     = (fcnt != '0) && i_upd_ready;
  assign res_ok  = i_res_valid && !ignore && (req_cnt != res_cnt);
  assign stray   = !ignore && ((i_MU_vel_valid && (rd_cnt == cap_cnt)) ||
                               (i_res_valid && (req_cnt == res_cnt)));
  assign wb_next = wb_cnt + CW'(wr_en);

  assign o_busy       = (state != IDLE);
  assign o_done       = (state == DONE);
  assign o_MU_working = (state == READ) || (state == DRAIN);
  assign o_err        = err;
  assign o_MU_rd_en   = rd_en;
  assign o_MU_rd_addr = rd_cnt[PARTICLE_ID_WIDTH-1:0];
  assign o_upd_valid  = (fcnt != '0);
  assign o_upd_vel    = fifo_vel[rptr];
  assign o_upd_id     = fifo_id[rptr];
  assign o_MU_wr_en   = wr_en;
  assign o_MU_wr_vel  = wr_vel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      num         <= '0;
      rd_cnt      <= '0;
      cap_cnt     <= '0;
      req_cnt     <= '0;
      res_cnt     <= '0;
      wb_cnt      <= '0;
      outstanding <= '0;
      ignore      <= 1'b1;
      err         <= 1'b0;
      wr_en       <= 1'b0;
      wr_vel      <= '0;
      wptr        <= '0;
      rptr        <= '0;
      fcnt        <= '0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        fifo_vel[i] <= '0;
        fifo_id[i]  <= '0;
      end
    end else begin
      if (stray)
        err <= 1'b1;
      wr_en <= res_ok;
      if (res_ok)
        wr_vel <= i_res_vel;

      if (cap) begin
        fifo_vel[wptr] <= i_MU_vel;
        fifo_id[wptr]  <= cap_cnt[PARTICLE_ID_WIDTH-1:0];
        wptr           <= wptr + 1'b1;
        cap_cnt        <= cap_cnt + 1'b1;
      end
      if (pop) begin
        rptr    <= rptr + 1'b1;
        req_cnt <= req_cnt + 1'b1;
      end
      fcnt <= fcnt + (AW+1)'(cap) - (AW+1)'(pop);
      if (res_ok)
        res_cnt <= res_cnt + 1'b1;
      if (rd_en)
        rd_cnt <= rd_cnt + 1'b1;
      outstanding <= outstanding + CW'(rd_en) - CW'(wr_en);
      wb_cnt      <= wb_next;

      case (state)
        IDLE: if (i_start) begin
          num         <= i_num_particles;
          rd_cnt      <= '0;
          cap_cnt     <= '0;
          req_cnt     <= '0;
          res_cnt     <= '0;
          wb_cnt      <= '0;
          outstanding <= '0;
          ignore      <= 1'b0;
          state       <= (i_num_particles == '0) ? DONE : READ;
        end
        READ:  if (rd_en && (rd_cnt == num - CW'(1))) state <= DRAIN;
        DRAIN: if (wb_next == num) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mu_vel_sequencer.sv
// Randomized bench for mu_vel_sequencer: emulated cache and update unit plus a
// count/queue-level model of the pass, compared against the DUT every cycle.
module tb_mu_vel_sequencer;
  localparam int PW  = 7;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic [PW:0]   i_num_particles = '0;
  logic          o_busy, o_done, o_err, o_MU_working, o_MU_rd_en, o_upd_valid, o_MU_wr_en;
  logic [PW-1:0] o_MU_rd_addr, o_upd_id;
  logic [95:0]   i_MU_vel = '0, o_upd_vel, i_res_vel = '0, o_MU_wr_vel;
  logic          i_MU_vel_valid = 1'b0, i_upd_ready = 1'b0, i_res_valid = 1'b0;

  mu_vel_sequencer #(.PARTICLE_ID_WIDTH(PW), .DATA_WIDTH(32), .MAX_INFLIGHT(MAX)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_particles(i_num_particles),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_MU_working(o_MU_working),
    .o_MU_rd_addr(o_MU_rd_addr), .o_MU_rd_en(o_MU_rd_en), .i_MU_vel(i_MU_vel),
    .i_MU_vel_valid(i_MU_vel_valid), .o_upd_vel(o_upd_vel), .o_upd_id(o_upd_id),
    .o_upd_valid(o_upd_valid), .i_upd_ready(i_upd_ready), .i_res_vel(i_res_vel),
    .i_res_valid(i_res_valid), .o_MU_wr_en(o_MU_wr_en), .o_MU_wr_vel(o_MU_wr_vel));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  // test controls
  bit ctl_rst = 1'b0, ctl_start = 1'b0, ctl_stray_res = 1'b0, ctl_stray_vel = 1'b0;
  int ctl_n = 0, ready_mode = 0, c_lo = 1, c_hi = 3, u_lo = 2, u_hi = 2;

  // emulated cache contents and in-order response pipes
  logic [95:0] mem [128];
  int c_time[$], c_addr[$], u_time[$], c_last = 0, u_last = 0;
  logic [95:0] u_val[$];

  // reference model: counts and a queue of particles waiting for the update unit
  typedef struct { int id; logic [95:0] vel; } ent_t;
  ent_t q[$];
  bit m_active = 0, m_done_due = 0, m_err = 0, m_ignore = 1, m_wr_en = 0, exp_rd_en = 0;
  int m_n = 0, m_issued = 0, m_written = 0, m_cap = 0, m_pops = 0, m_results = 0;
  logic [95:0] m_wr_vel = '0;

  // observations of the DUT, for the hand-computed checks
  int obs_rd = 0, obs_wr = 0, obs_done = 0, obs_work = 0, done_cyc = -1;
  int obs_addr[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_obs();
    obs_rd = 0; obs_wr = 0; obs_done = 0; obs_work = 0; done_cyc = -1;
    obs_addr.delete();
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 0; m_done_due = 0; m_err = 0; m_ignore = 1; m_wr_en = 0;
    m_n = 0; m_issued = 0; m_written = 0; m_cap = 0; m_pops = 0; m_results = 0;
    m_wr_vel = '0;
    c_time.delete(); c_addr.delete(); u_time.delete(); u_val.delete();
  endtask

  task automatic step();
    int t, old_issued, old_pops;
    bit idle, nxt_done, nxt_wr;
    @(negedge clk);
    cyc++;
    // compare this cycle's outputs with the model
    exp_rd_en = m_active && (m_issued < m_n) && ((m_issued - m_written) < MAX);
    check("busy", o_busy, m_active || m_done_due);
    check("working", o_MU_working, m_active);
    check("done", o_done, m_done_due);
    check("err", o_err, m_err);
    check("rd_en", o_MU_rd_en, exp_rd_en);
    if (exp_rd_en) check("rd_addr", o_MU_rd_addr, m_issued);
    check("upd_valid", o_upd_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("upd_id", o_upd_id, q[0].id);
      check("upd_vel", o_upd_vel, q[0].vel);
    end
    check("wr_en", o_MU_wr_en, m_wr_en);
    if (m_wr_en) check("wr_vel", o_MU_wr_vel, m_wr_vel);
    if (o_MU_rd_en) begin obs_rd++; obs_addr.push_back(int'(o_MU_rd_addr)); end
    if (o_MU_wr_en) obs_wr++;
    if (o_done) begin obs_done++; done_cyc = cyc; end
    if (o_MU_working) obs_work++;

    // drive this cycle's inputs
    rst = ctl_rst;
    i_start = 1'b0; i_MU_vel_valid = 1'b0; i_res_valid = 1'b0; i_upd_ready = 1'b0;
    if (!ctl_rst) begin
      model_reset();
      return;
    end
    i_start = ctl_start; i_num_particles = (PW+1)'(ctl_n); ctl_start = 1'b0;
    if (o_MU_rd_en) begin
      t = cyc + $urandom_range(c_hi, c_lo);
      if (t <= c_last) t = c_last + 1;
      c_last = t; c_time.push_back(t); c_addr.push_back(int'(o_MU_rd_addr));
    end
    if (c_time.size() > 0 && c_time[0] <= cyc) begin
      i_MU_vel_valid = 1'b1; i_MU_vel = mem[c_addr[0]];
      void'(c_time.pop_front()); void'(c_addr.pop_front());
    end
    if (ctl_stray_vel) begin i_MU_vel_valid = 1'b1; i_MU_vel = {$urandom, $urandom, $urandom}; end
    ctl_stray_vel = 1'b0;
    i_upd_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (o_upd_valid && i_upd_ready) begin
      t = cyc + $urandom_range(u_hi, u_lo);
      if (t <= u_last) t = u_last + 1;
      u_last = t; u_time.push_back(t); u_val.push_back(~o_upd_vel);
    end
    if (u_time.size() > 0 && u_time[0] <= cyc) begin
      i_res_valid = 1'b1; i_res_vel = u_val[0];
      void'(u_time.pop_front()); void'(u_val.pop_front());
    end
    if (ctl_stray_res) begin i_res_valid = 1'b1; i_res_vel = {$urandom, $urandom, $urandom}; end
    ctl_stray_res = 1'b0;

    // advance the model by this cycle
    idle = !m_active && !m_done_due;
    old_issued = m_issued; old_pops = m_pops;
    nxt_done = 0; nxt_wr = 0;
    if (exp_rd_en) m_issued++;
    if (q.size() > 0 && i_upd_ready) begin void'(q.pop_front()); m_pops++; end
    if (i_MU_vel_valid && !m_ignore) begin
      if (old_issued > m_cap) begin q.push_back('{m_cap, mem[m_cap]}); m_cap++; end
      else m_err = 1;
    end
    if (i_res_valid && !m_ignore) begin
      if (old_pops > m_results) begin nxt_wr = 1; m_wr_vel = ~mem[m_results]; m_results++; end
      else m_err = 1;
    end
    if (m_wr_en) begin
      m_written++;
      if (m_active && m_written == m_n) begin m_active = 0; nxt_done = 1; end
    end
    if (i_start && idle) begin
      m_n = ctl_n; m_issued = 0; m_written = 0; m_cap = 0; m_pops = 0; m_results = 0;
      m_ignore = 0;
      if (ctl_n == 0) nxt_done = 1; else m_active = 1;
    end
    m_wr_en = nxt_wr; m_done_due = nxt_done;
  endtask

  task automatic run_until_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (!m_active && !m_done_due && q.size() == 0 && c_time.size() == 0 && u_time.size() == 0)
        return;
      step();
    end
    total++; bad++;
    $display("FAIL %s timeout cyc=%0d busy=%0d want idle", name, cyc, o_busy);
  endtask

  task automatic start_pass(input int n);
    for (int i = 0; i < 128; i++) mem[i] = {$urandom, $urandom, $urandom};
    ctl_n = n; ctl_start = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    repeat (3) step();
    check("reset_busy", o_busy, 1'b0);
    check("reset_err", o_err, 1'b0);
    check("reset_upd_vel", o_upd_vel, 96'd0);
    check("reset_wr_vel", o_MU_wr_vel, 96'd0);
    check("reset_rd_addr", o_MU_rd_addr, 7'd0);
    ctl_rst = 1'b1;
    repeat (2) step();

    // N=6, ready high, 2-cycle loopback
    clear_obs(); ready_mode = 0; u_lo = 2; u_hi = 2;
    start_pass(6);
    run_until_idle("n6");
    check("n6_reads", obs_rd, 6);
    for (int i = 0; i < 6; i++) check("n6_addr", obs_addr[i], i);
    check("n6_writes", obs_wr, 6);
    check("n6_done_pulses", obs_done, 1);
    check("n6_err", o_err, 1'b0);

    // N=0: done the cycle after start, nothing else
    clear_obs();
    start_pass(0);
    t_n0: begin
      int s;
      s = cyc;
      run_until_idle("n0");
      step();
      check("n0_done_cycle", done_cyc, s + 1);
    end
    check("n0_working", obs_work, 0);
    check("n0_reads", obs_rd, 0);
    check("n0_writes", obs_wr, 0);

    // N=8 with update unit stalled for 20 cycles
    clear_obs(); ready_mode = 1;
    start_pass(8);
    repeat (19) step();
    check("stall_reads", obs_rd, MAX);
    check("stall_writes", obs_wr, 0);
    ready_mode = 0;
    run_until_idle("stall");
    check("stall_total_writes", obs_wr, 8);
    check("stall_done_pulses", obs_done, 1);

    // second start during READ is ignored
    clear_obs(); c_lo = 2; c_hi = 4;
    start_pass(10);
    repeat (2) step();
    check("restart_in_read", o_MU_working, 1'b1);
    ctl_n = 3; ctl_start = 1'b1;
    run_until_idle("restart");
    check("restart_reads", obs_rd, 10);
    check("restart_last_addr", obs_addr[9], 9);
    check("restart_done_pulses", obs_done, 1);

    // randomized passes, including the full 2^PW cell
    ready_mode = 2; c_lo = 1; c_hi = 4; u_lo = 1; u_hi = 4;
    for (int p = 0; p < 12; p++) begin
      start_pass($urandom_range(1, 40));
      run_until_idle("rand");
      repeat ($urandom_range(0, 3)) step();
    end
    clear_obs();
    start_pass(128);
    run_until_idle("n128");
    check("n128_writes", obs_wr, 128);
    check("n128_last_addr", obs_addr[127], 127);

    // stray result after a completed pass sets a sticky error
    step();
    ctl_stray_res = 1'b1;
    repeat (6) step();
    check("stray_err_sticky", o_err, 1'b1);

    // reset in DRAIN with two outstanding aborts cleanly
    ready_mode = 0; u_lo = 3; u_hi = 3;
    start_pass(8);
    t_dr: begin
      int k;
      for (k = 0; k < 200; k++) begin
        if (m_active && m_issued == m_n && (m_issued - m_written) == 2) break;
        step();
      end
      check("drain2_reached", k < 200, 1'b1);
    end
    ctl_rst = 1'b0;
    step();
    step();
    check("abort_busy", o_busy, 1'b0);
    check("abort_rd_en", o_MU_rd_en, 1'b0);
    check("abort_wr_en", o_MU_wr_en, 1'b0);
    check("abort_err", o_err, 1'b0);
    ctl_rst = 1'b1;
    step();
    ctl_stray_res = 1'b1; step();
    ctl_stray_vel = 1'b1; step();
    repeat (3) step();
    check("late_inputs_err", o_err, 1'b0);

    clear_obs(); ready_mode = 2;
    start_pass(5);
    run_until_idle("recover");
    check("recover_writes", obs_wr, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
